seg7_scan_driver: RTL
=====================

# seg7_scan_driver

Time-multiplexed driver for the board's eight-digit, common-anode seven-segment display. It consumes the 32-bit, eight-nibble word produced by the hex/decimal conversion stage: BCD when converted, raw hex otherwise. It snapshots that word once per scan frame so that no digit tears mid-frame, then scans the digits one at a time. It supports optional leading-zero blanking and per-digit decimal points, and decodes nibbles 0–F.

## Interface
- `REFRESH_DIV`, default 100_000: clock cycles each digit stays lit (1 kHz per digit at 100 MHz). Must be ≥ 2.
- `clk`  in  1: system clock. All logic is on the rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `enable`  in  1: scanning enable. Low blanks the display.
- `value`  in  32: eight nibbles. Nibble 0 (`value[3:0]`) is the rightmost digit.
- `blank_lz`  in  1: when 1, suppress leading zeros.
- `dp_mask`  in  8: decimal-point request per digit. Bit i belongs to digit i.
- `anodes`  out  8: digit selects, active-low. Bit i is digit i.
- `segments`  out  7: `{g,f,e,d,c,b,a}`, active-low.
- `dp`  out  1: decimal point, active-low.
- `frame_done`  out  1: one-cycle pulse when digit 7's slot ends.

## Operation
- State machine with three states: IDLE, LOAD, SCAN.
  - IDLE: if `enable`=1, go to LOAD; otherwise stay in IDLE.
  - LOAD: lasts exactly one cycle. Captures `value`, `dp_mask` and `blank_lz` into snapshot registers, clears `cnt` and `idx`, then goes to SCAN.
  - SCAN:
    - `cnt` counts 0…REFRESH_DIV-1.
    - At terminal count with `idx`<7: `idx`++ and `cnt`←0.
    - At terminal count with `idx`=7: assert `frame_done` and go to LOAD.
  - `enable`=0 in any state sends the machine to IDLE on the next edge. This has priority over every other transition.
- Snapshot isolation: changes on `value`, `dp_mask` or `blank_lz` are not visible until the next LOAD.
- Blanking rule: digit i (i≥1) is blank when snapshot `blank_lz`=1 and snapshot nibbles i..7 are all zero. Digit 0 is never blank.
- Per-digit drive while `idx`=i:
  - `segments` = decode(nibble i), or 7'h7F if the digit is blank.
  - `dp` = ~dp_mask_snap[i].
  - `anodes` = ~(1<<i), unless the digit is blank and dp_mask_snap[i]=0; in that case `anodes`=8'hFF.
- Decode values (active-low):
  - 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78
  - 8=7'h00, 9=7'h10, A=7'h08, b=7'h03, C=7'h46, d=7'h21, E=7'h06, F=7'h0E
- In IDLE and LOAD, all outputs are off: `anodes`=8'hFF, `segments`=7'h7F, `dp`=1.

## Timing
- Reset values:
  - State IDLE; `cnt`=0; `idx`=0; snapshots 0.
  - `anodes`=8'hFF, `segments`=7'h7F, `dp`=1, `frame_done`=0.
- Reset asserted mid-scan returns every register to its reset value on that edge.
- All outputs are registered and lag the state/`idx` by one cycle.
  - Example: the first SCAN cycle of digit 0 shows on the outputs one cycle after the LOAD→SCAN edge.
- Each digit is lit for exactly REFRESH_DIV cycles.
- Frame period is 8·REFRESH_DIV+1 cycles: eight digit slots plus one dark LOAD cycle.
- `frame_done` is registered. It is high for the single cycle after the SCAN→LOAD edge, which coincides with the last output cycle of digit 7.
- `enable` falling: outputs go dark 2 cycles later (state edge, then output register).
- `enable` rising: the first lit output appears 3 cycles later (IDLE→LOAD, LOAD→SCAN, output register).

## Structure
- Package `seg7_pkg` contains:
  - `typedef enum logic [1:0] {IDLE, LOAD, SCAN} scan_state_t`
  - `localparam NUM_DIGITS = 8`
  - `localparam logic [6:0] SEG_OFF = 7'h7F`
  - the 16-entry active-low decode constant array
- Sub-module `hex_to_7seg`: purely combinational, 4-bit nibble in, 7-bit active-low segments out. Instantiated once on the nibble selected by `idx`.
- Leading-zero mask: combinational, computed from the snapshot as a 8-bit "nibbles above are all zero" vector.

## Test plan
All scenarios run with REFRESH_DIV=4.
1. Reset then `enable`=1 with `value`=32'h0000_1234 and `blank_lz`=0.
   - Digits 0..7 show 4,3,2,1,0,0,0,0: segments 19,30,24,79,40,40,40,40.
   - Each digit is lit 4 cycles; `frame_done` pulses every 33 cycles.
2. `value`=32'h0000_0105, `blank_lz`=1, `dp_mask`=8'h08.
   - Digits 0–2 show 5,0,1.
   - Digit 3 has `anodes`=8'hF7, `segments`=7'h7F, `dp`=0.
   - Digits 4–7 have `anodes`=8'hFF.
3. `value`=0 with `blank_lz`=1: only digit 0 lights, showing 7'h40.
4. Change `value` from 32'h1111_1111 to 32'h2222_2222 while `idx`=3.
   - The current frame shows only 1s.
   - The next frame after LOAD shows only 2s.
5. `value`=32'hFEDC_BA98: the frame shows 00,10,08,03,46,21,06,0E for digits 0..7.
6. Drop `enable` mid-frame, and separately assert `reset` mid-frame.
   - `enable` drop: outputs are dark 2 cycles later.
   - `reset`: outputs are dark on the next cycle and state is IDLE.
   - Re-enabling after either event restarts at digit 0 with a fresh snapshot.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared types and constants for the eight-digit seven-segment scan driver.
// Segment patterns are active-low {g,f,e,d,c,b,a}.
package seg7_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, SCAN} scan_state_t;

  localparam int NUM_DIGITS = 8;
  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Entry n is the pattern for nibble n; the first element listed is nibble F.
  localparam logic [15:0][6:0] SEG_LUT = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational hex nibble to active-low seven-segment decoder.
module hex_to_7seg
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = SEG_LUT[nibble];

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed eight-digit common-anode display driver with per-frame
// snapshot, leading-zero blanking and per-digit decimal points.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV = 100_000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [31:0]           value,
  input  logic                  blank_lz,
  input  logic [NUM_DIGITS-1:0] dp_mask,
  output logic [NUM_DIGITS-1:0] anodes,
  output logic [6:0]            segments,
  output logic                  dp,
  output logic                  frame_done
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  scan_state_t           state;
  logic [CNT_W-1:0]      cnt;
  logic [2:0]            idx;
  logic [31:0]           value_snap;
  logic [NUM_DIGITS-1:0] dp_snap;
  logic                  blz_snap;

  logic [NUM_DIGITS-1:0] upper_zero;
  logic [NUM_DIGITS-1:0] blank_vec;
  logic [3:0]            nib;
  logic [6:0]            dec_seg;
  logic                  tc;
  logic                  blank_cur;
  logic                  dp_cur;

  assign tc = (cnt == CNT_LAST);

  // upper_zero[i]: snapshot nibbles i..7 are all zero
  always_comb begin
    upper_zero = '0;
    upper_zero[7] = (value_snap[31:28] == 4'h0);
    for (int i = 6; i >= 0; i--) begin
      upper_zero[i] = upper_zero[i+1] && (value_snap[i*4 +: 4] == 4'h0);
    end
  end

  assign blank_vec = {upper_zero[7:1] & {7{blz_snap}}, 1'b0};
  assign nib       = value_snap[{idx, 2'b00} +: 4];
  assign blank_cur = blank_vec[idx];
  assign dp_cur    = dp_snap[idx];

  hex_to_7seg u_dec (
    .nibble (nib),
    .seg    (dec_seg)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      value_snap <= '0;
      dp_snap    <= '0;
      blz_snap   <= 1'b0;
    end else if (!enable) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: state <= LOAD;
        LOAD: begin
          value_snap <= value;
          dp_snap    <= dp_mask;
          blz_snap   <= blank_lz;
          cnt        <= '0;
          idx        <= '0;
          state      <= SCAN;
        end
        SCAN: begin
          if (tc) begin
            cnt <= '0;
            if (idx == 3'd7) state <= LOAD;
            else             idx   <= idx + 3'd1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Output register: drives the digit selected by the current state/idx
  always_ff @(posedge clk) begin
    if (reset) begin
      anodes     <= 8'hFF;
      segments   <= SEG_OFF;
      dp         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      frame_done <= enable && (state == SCAN) && tc && (idx == 3'd7);
      if (state == SCAN) begin
        segments <= blank_cur ? SEG_OFF : dec_seg;
        dp       <= ~dp_cur;
        anodes   <= (blank_cur && !dp_cur) ? 8'hFF : ~(8'h01 << idx);
      end else begin
        anodes   <= 8'hFF;
        segments <= SEG_OFF;
        dp       <= 1'b1;
      end
    end
  end

endmodule
